// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the memory port arbiter.
// master is the arbiter's view; slave is the view of the core and memory around it.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output busy
    );

    modport slave (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, one transaction
// in flight. Load/store wins by default; a starvation counter forces a fetch grant.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned      BE_W       = DATA_W / 8;
    localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic              owner_d_q,   owner_d_d;
    logic [CNT_W-1:0]  starve_q,    starve_d;
    logic              mem_we_q,    mem_we_d;
    logic [BE_W-1:0]   mem_be_q,    mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_rvalid_q,  i_rvalid_d;
    logic              d_rvalid_q,  d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

    logic arb_c;
    logic d_pick_c;
    logic i_pick_c;
    logic resp_c;

    // Arbitration, transaction latch and response routing
    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        starve_d    = starve_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        // Grants are held off while reset is asserted so none leak out during reset.
        arb_c    = rst && (state_q == IDLE);
        d_pick_c = arb_c && bus.d_req && !(bus.i_req && (starve_q == STARVE_LIM));
        i_pick_c = arb_c && bus.i_req && !d_pick_c;
        resp_c   = bus.mem_rvalid &&
                   (((state_q == ISSUE) && bus.mem_gnt) || (state_q == WAIT));

        case (state_q)
            IDLE:    if (d_pick_c || i_pick_c) state_d = ISSUE;
            ISSUE:   if (bus.mem_gnt) state_d = resp_c ? IDLE : WAIT;
            WAIT:    if (resp_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (d_pick_c) begin
            owner_d_d   = 1'b1;
            mem_we_d    = bus.d_we;
            mem_be_d    = bus.d_be;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            if (bus.i_req && (starve_q != STARVE_LIM)) starve_d = starve_q + CNT_W'(1);
        end
        if (i_pick_c) begin
            owner_d_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
        end

        if (resp_c) begin
            if (owner_d_q) begin
                d_rdata_d  = bus.mem_rdata;
                d_rvalid_d = 1'b1;
            end else begin
                i_rdata_d  = bus.mem_rdata;
                i_rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            starve_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            starve_q    <= starve_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.i_gnt     = i_pick_c;
    assign bus.d_gnt     = d_pick_c;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = (state_q == ISSUE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration and response rules.
module tb_mem_port_arbiter;
    localparam int unsigned STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    task automatic drive_zero();
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        drive_zero();
        rst = 0;
        bus.i_req = 1; bus.d_req = 1; bus.d_addr = 32'h40; bus.i_addr = 32'h44;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({bus.i_gnt, bus.d_gnt} !== 2'b00) begin
                errors++; $display("FAIL reset_gnt: got %b want 00", {bus.i_gnt, bus.d_gnt});
            end
            outs = {bus.busy, bus.mem_req, bus.mem_we, bus.i_rvalid, bus.d_rvalid, 27'd0} |
                   {28'd0, bus.mem_be} | bus.mem_addr | bus.mem_wdata | bus.i_rdata | bus.d_rdata;
            checks++;
            if (outs !== 32'h0) begin
                errors++; $display("FAIL reset_outputs: got %h want 0", outs);
            end
        end
        @(negedge clk); rst = 1; #1;
        checks++;
        if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
            errors++; $display("FAIL reset_release_gnt: got i/d=%b want 01", {bus.i_gnt, bus.d_gnt});
        end
        @(negedge clk);
        bus.i_req = 0; bus.d_req = 0;
        bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h11112222; #1;
        checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h40}) begin
            errors++; $display("FAIL reset_release_issue: got req=%b addr=%h want 1/40", bus.mem_req, bus.mem_addr);
        end
        @(negedge clk); drive_zero(); #1;
        checks++;
        if ({bus.d_rvalid, bus.i_rvalid, bus.d_rdata} !== {2'b10, 32'h11112222}) begin
            errors++; $display("FAIL reset_release_resp: got dv=%b iv=%b d_rdata=%h want 1/0/11112222",
                               bus.d_rvalid, bus.i_rvalid, bus.d_rdata);
        end
    endtask

    task automatic test_single_fetch();
        @(negedge clk); drive_zero(); bus.i_req = 1; bus.i_addr = 32'h100; #1;
        checks++;
        if ({bus.i_gnt, bus.d_gnt, bus.busy} !== 3'b100) begin
            errors++; $display("FAIL fetch_gnt: got i/d/busy=%b want 100", {bus.i_gnt, bus.d_gnt, bus.busy});
        end
        @(negedge clk); bus.i_req = 0; bus.i_addr = 32'hFFFF_0000; bus.mem_gnt = 1; #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.i_gnt}
            !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0}) begin
            errors++; $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h wdata=%h ignt=%b",
                               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.i_gnt);
        end
        @(negedge clk); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h00500093; #1;
        checks++;
        if ({bus.mem_req, bus.i_rvalid, bus.busy} !== 3'b001) begin
            errors++; $display("FAIL fetch_wait: got req/irv/busy=%b want 001", {bus.mem_req, bus.i_rvalid, bus.busy});
        end
        @(negedge clk); bus.mem_rvalid = 0; bus.mem_rdata = 32'h0; #1;
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.busy, bus.i_rdata} !== {3'b100, 32'h00500093}) begin
            errors++; $display("FAIL fetch_resp: got irv/drv/busy=%b i_rdata=%h want 100/00500093",
                               {bus.i_rvalid, bus.d_rvalid, bus.busy}, bus.i_rdata);
        end
        @(negedge clk); #1;
        checks++;
        if ({bus.i_rvalid, bus.i_rdata} !== {1'b0, 32'h00500093}) begin
            errors++; $display("FAIL fetch_hold: got irv=%b i_rdata=%h want 0/00500093", bus.i_rvalid, bus.i_rdata);
        end
    endtask

    task automatic test_store();
        @(negedge clk); drive_zero();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'hF; #1;
        checks++;
        if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
            errors++; $display("FAIL store_gnt: got i/d=%b want 01", {bus.i_gnt, bus.d_gnt});
        end
        @(negedge clk); bus.d_req = 0; bus.d_we = 0; bus.d_wdata = 32'h0; bus.d_be = 4'h0; bus.mem_gnt = 1; #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}
            !== {1'b1, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF}) begin
            errors++; $display("FAIL store_issue: got req=%b we=%b be=%h addr=%h wdata=%h",
                               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678; #1;
        @(negedge clk); bus.mem_rvalid = 0; #1;
        checks++;
        if ({bus.d_rvalid, bus.i_rvalid, bus.d_rdata, bus.i_rdata} !== {2'b10, 32'h12345678, 32'h00500093}) begin
            errors++; $display("FAIL store_resp: got drv=%b irv=%b d_rdata=%h i_rdata=%h",
                               bus.d_rvalid, bus.i_rvalid, bus.d_rdata, bus.i_rdata);
        end
    endtask

    task automatic test_starvation();
        int ngr = 0;
        int cyc = 0;
        logic exp_d;
        @(negedge clk); drive_zero();
        bus.i_req = 1; bus.d_req = 1; bus.i_addr = 32'h1000; bus.d_addr = 32'h2000;
        while (ngr < 10 && cyc < 100) begin
            if (cyc != 0) @(negedge clk);
            bus.mem_gnt = bus.mem_req; bus.mem_rvalid = bus.mem_req; bus.mem_rdata = $urandom;
            #1;
            if (bus.i_gnt || bus.d_gnt) begin
                exp_d = (ngr % (STARVE_MAX + 1)) != STARVE_MAX;
                checks++;
                if ({bus.d_gnt, bus.i_gnt} !== {exp_d, !exp_d}) begin
                    errors++; $display("FAIL starve_order[%0d]: got d/i=%b%b want %b%b",
                                       ngr, bus.d_gnt, bus.i_gnt, exp_d, !exp_d);
                end
                ngr++;
            end
            cyc++;
        end
        checks++;
        if (ngr < 10) begin
            errors++; $display("FAIL starve_timeout: got %0d grants want 10", ngr);
        end
        repeat (3) begin
            @(negedge clk); bus.i_req = 0; bus.d_req = 0;
            bus.mem_gnt = bus.mem_req; bus.mem_rvalid = bus.mem_req;
        end
        @(negedge clk); drive_zero();
    endtask

    task automatic test_stall();
        @(negedge clk); drive_zero();
        bus.d_req = 1; bus.d_addr = 32'h300; bus.d_be = 4'h3; #1;
        checks++;
        if (bus.d_gnt !== 1'b1) begin
            errors++; $display("FAIL stall_gnt: got %b want 1", bus.d_gnt);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.d_req = 0; bus.d_addr = $urandom; bus.i_req = 1; bus.i_addr = 32'h600; bus.mem_gnt = 0;
            #1;
            checks++;
            if ({bus.mem_req, bus.busy, bus.i_gnt, bus.d_gnt, bus.mem_we, bus.mem_be, bus.mem_addr}
                !== {4'b1100, 1'b0, 4'h3, 32'h300}) begin
                errors++; $display("FAIL stall_hold[%0d]: got req/busy/ig/dg=%b we=%b be=%h addr=%h", k,
                                   {bus.mem_req, bus.busy, bus.i_gnt, bus.d_gnt}, bus.mem_we, bus.mem_be, bus.mem_addr);
            end
        end
        @(negedge clk); bus.mem_gnt = 1; #1;
        @(negedge clk); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFEF00D; #1;
        checks++;
        if ({bus.i_gnt, bus.busy} !== 2'b01) begin
            errors++; $display("FAIL stall_wait: got ignt/busy=%b want 01", {bus.i_gnt, bus.busy});
        end
        @(negedge clk); bus.mem_rvalid = 0; #1;
        checks++;
        if ({bus.d_rvalid, bus.i_gnt, bus.d_rdata} !== {2'b11, 32'hCAFEF00D}) begin
            errors++; $display("FAIL stall_resp: got drv=%b ignt=%b d_rdata=%h want 1/1/cafef00d",
                               bus.d_rvalid, bus.i_gnt, bus.d_rdata);
        end
        @(negedge clk); bus.i_req = 0; bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0BADCAFE; #1;
        checks++;
        if (bus.mem_addr !== 32'h600) begin
            errors++; $display("FAIL stall_next_addr: got %h want 600", bus.mem_addr);
        end
        @(negedge clk); drive_zero(); #1;
        checks++;
        if ({bus.i_rvalid, bus.i_rdata} !== {1'b1, 32'h0BADCAFE}) begin
            errors++; $display("FAIL stall_next_resp: got irv=%b i_rdata=%h want 1/0badcafe", bus.i_rvalid, bus.i_rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk); drive_zero(); bus.i_req = 1; bus.i_addr = 32'h400; #1;
        @(negedge clk); bus.i_req = 0; bus.mem_gnt = 1; #1;
        @(negedge clk); bus.mem_gnt = 0; rst = 0; #1;
        checks++;
        if ({bus.busy, bus.mem_req} !== 2'b10) begin
            errors++; $display("FAIL rstwait_inwait: got busy/req=%b want 10", {bus.busy, bus.mem_req});
        end
        @(negedge clk); rst = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0BAD0; #1;
        checks++;
        if ({bus.busy, bus.mem_req, bus.i_rdata, bus.d_rdata} !== {2'b00, 64'h0}) begin
            errors++; $display("FAIL rstwait_cleared: got busy/req=%b i_rdata=%h d_rdata=%h",
                               {bus.busy, bus.mem_req}, bus.i_rdata, bus.d_rdata);
        end
        @(negedge clk); bus.mem_rvalid = 0; #1;
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata} !== {2'b00, 32'h0}) begin
            errors++; $display("FAIL rstwait_stray: got irv=%b drv=%b i_rdata=%h want 0/0/0",
                               bus.i_rvalid, bus.d_rvalid, bus.i_rdata);
        end
        @(negedge clk); bus.d_req = 1; bus.d_addr = 32'h500; #1;
        checks++;
        if (bus.d_gnt !== 1'b1) begin
            errors++; $display("FAIL rstwait_next_gnt: got %b want 1", bus.d_gnt);
        end
        @(negedge clk); bus.d_req = 0; bus.mem_gnt = 1; #1;
        @(negedge clk); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h55AA55AA; #1;
        @(negedge clk); bus.mem_rvalid = 0; #1;
        checks++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h55AA55AA}) begin
            errors++; $display("FAIL rstwait_next_resp: got drv=%b d_rdata=%h want 1/55aa55aa", bus.d_rvalid, bus.d_rdata);
        end
    endtask

    task automatic test_random();
        logic        ir = 0, dr = 0, dwe = 0;
        logic [31:0] ia = 0, da = 0, dwd = 0;
        logic [3:0]  dbe = 0;
        logic        act = 0, mgd = 0, own_d = 0, rv_i = 0, rv_d = 0;
        logic [31:0] ex_i = 0, ex_d = 0;
        logic [68:0] ex_f = '0;
        int unsigned starve = 0;
        logic        mg, mrv, win_i, win_d;
        logic [31:0] mrd;
        @(negedge clk); drive_zero(); rst = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = 1;
            if (!ir) begin
                ia = $urandom;
                ir = ($urandom_range(0, 2) == 0);
            end
            if (!dr) begin
                dwe = 1'($urandom); dbe = 4'($urandom); da = $urandom; dwd = $urandom;
                dr = ($urandom_range(0, 2) == 0);
            end
            mg = 0; mrv = 0; mrd = $urandom;
            if (act && !mgd) begin
                mg = 1'($urandom);
                if (mg) mrv = ($urandom_range(0, 2) == 0);
            end else if (act) begin
                mrv = 1'($urandom);
            end else begin
                mrv = ($urandom_range(0, 7) == 0);
            end
            bus.i_req = ir; bus.i_addr = ia;
            bus.d_req = dr; bus.d_we = dwe; bus.d_be = dbe; bus.d_addr = da; bus.d_wdata = dwd;
            bus.mem_gnt = mg; bus.mem_rvalid = mrv; bus.mem_rdata = mrd;
            #1;
            win_d = !act && dr && !(ir && starve == STARVE_MAX);
            win_i = !act && ir && !win_d;
            checks++;
            if ({bus.i_gnt, bus.d_gnt} !== {win_i, win_d}) begin
                errors++; $display("FAIL rand_gnt@%0d: got i/d=%b%b want %b%b", c, bus.i_gnt, bus.d_gnt, win_i, win_d);
            end
            checks++;
            if ({bus.busy, bus.mem_req} !== {act, act && !mgd}) begin
                errors++; $display("FAIL rand_state@%0d: got busy/req=%b%b want %b%b",
                                   c, bus.busy, bus.mem_req, act, act && !mgd);
            end
            if (act && !mgd) begin
                checks++;
                if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== ex_f) begin
                    errors++; $display("FAIL rand_fields@%0d: got %h want %h", c,
                                       {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, ex_f);
                end
            end
            checks++;
            if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata} !== {rv_i, rv_d, ex_i, ex_d}) begin
                errors++; $display("FAIL rand_resp@%0d: got iv=%b dv=%b i=%h d=%h want %b %b %h %h", c,
                                   bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata, rv_i, rv_d, ex_i, ex_d);
            end
            rv_i = 0; rv_d = 0;
            if (act && mrv && (mgd || mg)) begin
                if (own_d) begin rv_d = 1; ex_d = mrd; end
                else       begin rv_i = 1; ex_i = mrd; end
                act = 0; mgd = 0;
            end else if (act && mg) begin
                mgd = 1;
            end
            if (win_d) begin
                ex_f = {dwe, dbe, da, dwd}; own_d = 1; act = 1; mgd = 0; dr = 0;
                if (ir && starve < STARVE_MAX) starve++;
            end
            if (win_i) begin
                ex_f = {1'b0, 4'hF, ia, 32'h0}; own_d = 0; act = 1; mgd = 0; ir = 0;
                starve = 0;
            end
        end
        for (int k = 0; k < 10 && bus.busy; k++) begin
            @(negedge clk); bus.i_req = 0; bus.d_req = 0;
            bus.mem_gnt = bus.mem_req; bus.mem_rvalid = bus.busy;
        end
        @(negedge clk); drive_zero(); #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL rand_drain: got busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        drive_zero();
        test_reset();
        test_single_fetch();
        test_store();
        test_starvation();
        test_stall();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
